// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI responder: oversampled {data,addr} frame receive, preloaded byte return on MISO
module spi_slave_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              cs_in,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic              miso_oe_out,
  input  logic [DATA_W-1:0] tx_data_in,
  input  logic              tx_load_in,
  output logic              tx_busy_out,
  output logic              rx_valid_out,
  output logic [DATA_W-1:0] rx_data_out,
  output logic [ADDR_W-1:0] rx_addr_out,
  output logic              err_out
);

  localparam int FRAME_W = DATA_W + ADDR_W;
  // Sized so the saturation value FRAME_W+1 always fits.
  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]         state;
  logic               cs_s1, cs_s2, cs_s3;
  logic               sclk_s1, sclk_s2, sclk_s3;
  logic               mosi_s1, mosi_s2;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  tx_shadow;
  logic [DATA_W-1:0]  tx_sr;
  logic [FRAME_W-1:0] rx_sr;

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  always_comb begin
    cs_fall   = ~cs_s2 & cs_s3;
    cs_rise   = cs_s2 & ~cs_s3;
    sclk_rise = sclk_s2 & ~sclk_s3;
    sclk_fall = ~sclk_s2 & sclk_s3;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      cs_s1        <= 1'b0;
      cs_s2        <= 1'b0;
      cs_s3        <= 1'b0;
      sclk_s1      <= 1'b0;
      sclk_s2      <= 1'b0;
      sclk_s3      <= 1'b0;
      mosi_s1      <= 1'b0;
      mosi_s2      <= 1'b0;
      cnt          <= '0;
      tx_shadow    <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      miso_out     <= 1'b0;
      miso_oe_out  <= 1'b0;
      tx_busy_out  <= 1'b0;
      rx_valid_out <= 1'b0;
      rx_data_out  <= '0;
      rx_addr_out  <= '0;
      err_out      <= 1'b0;
    end else begin
      cs_s1   <= cs_in;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      sclk_s1 <= sclk_in;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= mosi_in;
      mosi_s2 <= mosi_s1;

      rx_valid_out <= 1'b0;
      err_out      <= 1'b0;

      // A load racing the frame start would be half-applied, so it is dropped.
      if (tx_load_in && !tx_busy_out && !(state == S_IDLE && cs_fall))
        tx_shadow <= tx_data_in;

      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state       <= S_SHIFT;
            cnt         <= '0;
            tx_busy_out <= 1'b1;
            miso_oe_out <= 1'b1;
            tx_sr       <= tx_shadow;
            miso_out    <= tx_shadow[DATA_W-1];
          end
        end
        S_SHIFT: begin
          if (cs_rise) begin
            state       <= S_IDLE;
            tx_busy_out <= 1'b0;
            miso_oe_out <= 1'b0;
            miso_out    <= 1'b0;
            if (cnt == CNT_FULL) begin
              rx_valid_out <= 1'b1;
              rx_data_out  <= rx_sr[FRAME_W-1:ADDR_W];
              rx_addr_out  <= rx_sr[ADDR_W-1:0];
            end else begin
              err_out <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_sr <= {rx_sr[FRAME_W-2:0], mosi_s2};
              if (cnt != CNT_SAT)
                cnt <= cnt + CNT_W'(1);
            end
            if (sclk_fall) begin
              tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
              miso_out <= tx_sr[DATA_W-2];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - directed self-checking bench for spi_slave_if
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk_in = 1'b0;
  logic       cs_in = 1'b1;
  logic       mosi_in = 1'b0;
  logic       miso_out, miso_oe_out, tx_busy_out, rx_valid_out, err_out;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx_load_in = 1'b0;
  logic [7:0] rx_data_out;
  logic [3:0] rx_addr_out;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  logic [15:0] miso_bits;
  logic        busy_seen;
  int          v0, e0;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .cs_in(cs_in), .mosi_in(mosi_in),
    .miso_out(miso_out), .miso_oe_out(miso_oe_out), .tx_data_in(tx_data_in),
    .tx_load_in(tx_load_in), .tx_busy_out(tx_busy_out), .rx_valid_out(rx_valid_out),
    .rx_data_out(rx_data_out), .rx_addr_out(rx_addr_out), .err_out(err_out)
  );

  always @(negedge clk) begin
    if (rx_valid_out) valid_cnt++;
    if (err_out) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master side, mode 0: drop CS, shift n bits MSB-first, leave CS low.
  task automatic spi_xfer(input logic [15:0] bits, input int n, input bit mid_load,
                          output logic [15:0] miso, output logic busy);
    miso = '0;
    busy = 1'b0;
    @(negedge clk) cs_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      mosi_in = bits[n-1-i];
      repeat (4) @(negedge clk);
      miso = {miso[14:0], miso_out};
      sclk_in = 1'b1;
      if (i == 4) begin
        busy = tx_busy_out;
        if (mid_load) begin
          tx_data_in = 8'hFF;
          tx_load_in = 1'b1;
          @(negedge clk) tx_load_in = 1'b0;
          repeat (3) @(negedge clk);
        end else begin
          repeat (4) @(negedge clk);
        end
      end else begin
        repeat (4) @(negedge clk);
      end
      sclk_in = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame();
    cs_in = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data_in = d;
    tx_load_in = 1'b1;
    @(negedge clk) tx_load_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    check("rst_miso", miso_out, 0);
    check("rst_oe", miso_oe_out, 0);
    check("rst_busy", tx_busy_out, 0);
    check("rst_valid", rx_valid_out, 0);
    check("rst_err", err_out, 0);
    check("rst_data", rx_data_out, 0);
    check("rst_addr", rx_addr_out, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 1 good write
    spi_xfer(16'hA53, 12, 1'b0, miso_bits, busy_seen);
    end_frame();
    check("s1_valid_cnt", valid_cnt, 1);
    check("s1_err_cnt", err_cnt, 0);
    check("s1_data", rx_data_out, 8'hA5);
    check("s1_addr", rx_addr_out, 4'h3);
    check("s1_miso_zero", miso_bits, 16'h000);

    // 2 readback with a dropped mid-frame load
    load_tx(8'h5C);
    spi_xfer(16'hA53, 12, 1'b1, miso_bits, busy_seen);
    check("s2_oe_during", miso_oe_out, 1);
    end_frame();
    check("s2_miso", miso_bits, 16'h5C0);
    check("s2_busy", busy_seen, 1);
    check("s2_busy_after", tx_busy_out, 0);
    check("s2_oe_after", miso_oe_out, 0);
    spi_xfer(16'hA53, 12, 1'b0, miso_bits, busy_seen);
    end_frame();
    check("s2_miso_again", miso_bits, 16'h5C0);
    check("s2_valid_cnt", valid_cnt, 3);

    // 3 short and long frames
    spi_xfer(16'h123, 11, 1'b0, miso_bits, busy_seen);
    end_frame();
    check("s3_err_short", err_cnt, 1);
    spi_xfer(16'h1FFF, 13, 1'b0, miso_bits, busy_seen);
    end_frame();
    check("s3_err_long", err_cnt, 2);
    check("s3_valid_cnt", valid_cnt, 3);
    check("s3_data", rx_data_out, 8'hA5);
    check("s3_addr", rx_addr_out, 4'h3);

    // 4 reset mid-frame
    spi_xfer(16'h1F, 5, 1'b0, miso_bits, busy_seen);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("s4_busy", tx_busy_out, 0);
    check("s4_oe", miso_oe_out, 0);
    check("s4_data", rx_data_out, 0);
    v0 = valid_cnt;
    e0 = err_cnt;
    end_frame();
    check("s4_no_valid", valid_cnt, v0);
    check("s4_no_err", err_cnt, e0);
    spi_xfer(16'h0F9, 12, 1'b0, miso_bits, busy_seen);
    end_frame();
    check("s4_valid", valid_cnt, v0 + 1);
    check("s4_data2", rx_data_out, 8'h0F);
    check("s4_addr2", rx_addr_out, 4'h9);
    check("s4_miso_shadow_clr", miso_bits, 16'h000);

    // 5 empty select
    e0 = err_cnt;
    v0 = valid_cnt;
    @(negedge clk) cs_in = 1'b0;
    repeat (10) @(negedge clk);
    check("s5_oe_sel", miso_oe_out, 1);
    repeat (10) @(negedge clk);
    end_frame();
    check("s5_err", err_cnt, e0 + 1);
    check("s5_no_valid", valid_cnt, v0);
    check("s5_oe_desel", miso_oe_out, 0);

    // 6 strobe latency and width
    spi_xfer(16'hA53, 12, 1'b0, miso_bits, busy_seen);
    cs_in = 1'b1;
    @(posedge clk) #1 check("s6_edge1", rx_valid_out, 0);
    @(posedge clk) #1 check("s6_edge2", rx_valid_out, 0);
    @(posedge clk) #1 check("s6_edge3", rx_valid_out, 1);
    @(posedge clk) #1 check("s6_edge4", rx_valid_out, 0);
    repeat (6) @(negedge clk);
    check("s6_data", rx_data_out, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
